interface_wheel_emulator: RTL
=============================

// Module: interface_wheel_emulator
// PURPOSE
//  Quadrature wheel emulator: produces channel A/B waveforms, the inverse of the wheel decoder.
//  Accepts step commands (count, direction, edge period) over a valid/ready handshake.
//  Drives A/B so the decoder counts CW on A rising with B=0 and CCW on A rising with B=1.
//  Used as bench stimulus and as the HIL wheel source on the Cyclone Cruiser board.
// PARAMETERS
//  STEP_WIDTH     16  width of cmd_steps and of the internal steps-remaining counter
//  DIV_WIDTH      16  width of cmd_period and of the internal edge divider
//  POS_WIDTH      16  width of pos_count (two's complement, wraps)
//  COUNTS_PER_REV 64  quadrature edges per revolution; multiple of 4; used by index only
// PORTS
//  clk         in   1           system clock; all logic on posedge
//  reset       in   1           synchronous, active-high reset
//  cmd_valid   in   1           command offered
//  cmd_ready   out  1           1 only in IDLE; transfer = cmd_valid & cmd_ready at posedge
//  cmd_steps   in   STEP_WIDTH  number of quadrature edges to emit
//  cmd_dir     in   1           1 = CW, 0 = CCW
//  cmd_period  in   DIV_WIDTH   clocks per quadrature edge; 0 treated as 1
//  abort       in   1           stop the active command at the next edge
//  A, B        out  1           quadrature outputs, registered
//  busy        out  1           1 in RUN
//  done        out  1           one-cycle pulse at command completion or abort
//  pos_count   out  POS_WIDTH   +1 per CW edge, -1 per CCW edge
//  Z           out  1           index output; see CONFIGURATION
// BEHAVIOUR
//  Reset: state=IDLE, A=0, B=0, phase=0, pos_count=0, busy=0, done=0, cmd_ready=1.
//  cmd_ready is combinational: state==IDLE.
//  Handshake is ignored while reset is high.
//  Phase to (A,B) Gray map: 0=00, 1=10, 2=11, 3=01.
//  - CW: phase+1 mod 4.
//  - CCW: phase-1 mod 4.
//  - Exactly one of A/B toggles per edge.
//  States:
//  - IDLE: on transfer, latch steps, dir and period (0 becomes 1).
//    - steps==0: go to DONE.
//    - Otherwise: go to RUN with div = period-1.
//  - RUN: div decrements each cycle. When div==0:
//    - Advance phase (A/B update at that edge), update pos_count, steps-1.
//    - steps reaches 0: go to DONE.
//    - Otherwise: reload div = period-1.
//  - DONE: done=1 for exactly one cycle, then IDLE.
//  Timing:
//  - Transfer at edge T0 gives edges k=1..N at T0 + k*period.
//  - done is high in the cycle after edge N; cmd_ready is high one cycle later.
//  abort in RUN:
//  - Go to DONE at that edge; no phase change on that edge, even if div==0.
//  - A/B hold their level; remaining steps are discarded.
//  - abort in IDLE or DONE has no effect.
//  Phase and pos_count persist across commands, so back-to-back commands stay glitch-free.
//  pos_count wraps modulo 2^POS_WIDTH.
//  Reset mid-RUN: immediate return to reset values, including A=B=0.
//  This may produce a double toggle, which is acceptable.
// CONFIGURATION
//  INTERFACE_WHEEL_INDEX_EN defined:
//  - Internal rev counter 0..COUNTS_PER_REV-1: +1 on CW edge, -1 on CCW edge, wraps both ways.
//  - Reset value 0.
//  - Z = registered (rev==0 && phase==0), so Z=1 out of reset.
//  INTERFACE_WHEEL_INDEX_EN undefined:
//  - No rev counter.
//  - Z tied to 0; the port is kept.
// TESTING
//  1. Reset, then steps=4, dir=1, period=3 -> A/B 10,11,01,00 at T0+3,6,9,12; pos_count=4; done@T0+13.
//  2. steps=4, dir=0, period=1 -> A/B 01,11,10,00 on consecutive clocks; pos_count=-4 (0xFFFC).
//  3. steps=0 -> no A/B change; done one cycle after transfer; cmd_ready back the next cycle.
//  4. steps=100, period=2; abort at 5th edge time -> 4 edges only; A/B hold; done single pulse.
//  5. CW 6 edges, then immediate CCW 6 edges -> no double toggle at the boundary; pos_count=0.
//  6. INDEX_EN, CPR=64: CW 64 edges, period=1 -> Z=1 at start and after edge 64 only; CCW 1 edge -> Z=0.

Source files
------------

// File: rtl/interface_wheel_emulator_if.sv
// Command channel for the quadrature wheel emulator: the step count, the direction
// and the edge period, transferred on a valid/ready handshake.
interface interface_wheel_emulator_if #(
    parameter int STEP_WIDTH = 16,
    parameter int DIV_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [STEP_WIDTH-1:0] cmd_steps;
    logic                  cmd_dir;
    logic [DIV_WIDTH-1:0]  cmd_period;

    modport master (output cmd_valid, cmd_steps, cmd_dir, cmd_period, input cmd_ready);
    modport slave  (input cmd_valid, cmd_steps, cmd_dir, cmd_period, output cmd_ready);
endinterface

// File: rtl/interface_wheel_emulator.sv
// Quadrature wheel emulator: turns step commands into registered A/B Gray-code edges.
// Optional index output Z is enabled by defining INTERFACE_WHEEL_INDEX_EN.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// RUN   | emitting edges, one every period clocks
// DONE  | one-cycle done pulse, then back to IDLE
module interface_wheel_emulator #(
    parameter int STEP_WIDTH     = 16,
    parameter int DIV_WIDTH      = 16,
    parameter int POS_WIDTH      = 16,
    parameter int COUNTS_PER_REV = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    interface_wheel_emulator_if.slave cmd,
    input  logic                 abort,
    output logic                 A,
    output logic                 B,
    output logic                 busy,
    output logic                 done,
    output logic [POS_WIDTH-1:0] pos_count,
    output logic                 Z
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_next;
    logic                  load, step_en;
    logic [STEP_WIDTH-1:0] steps_q;
    logic [DIV_WIDTH-1:0]  div_q, period_q, period_eff;
    logic                  dir_q;
    logic [1:0]            phase, phase_next;

    assign period_eff = (cmd.cmd_period == '0) ? DIV_WIDTH'(1) : cmd.cmd_period;
    assign phase_next = dir_q ? phase + 2'd1 : phase - 2'd1;

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state == RUN);
    assign done          = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step_en    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    load       = 1'b1;
                    state_next = (cmd.cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // abort wins over a due edge so A/B hold their level
                if (abort) begin
                    state_next = DONE;
                end else if (div_q == '0) begin
                    step_en = 1'b1;
                    if (steps_q == STEP_WIDTH'(1)) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= 2'd0;
            A         <= 1'b0;
            B         <= 1'b0;
            pos_count <= '0;
            steps_q   <= '0;
            div_q     <= '0;
            period_q  <= DIV_WIDTH'(1);
            dir_q     <= 1'b0;
        end else if (load) begin
            steps_q  <= cmd.cmd_steps;
            dir_q    <= cmd.cmd_dir;
            period_q <= period_eff;
            div_q    <= period_eff - DIV_WIDTH'(1);
        end else if (step_en) begin
            // Gray map 0=00 1=10 2=11 3=01 gives A = p1^p0, B = p1
            phase     <= phase_next;
            A         <= phase_next[1] ^ phase_next[0];
            B         <= phase_next[1];
            pos_count <= dir_q ? pos_count + POS_WIDTH'(1) : pos_count - POS_WIDTH'(1);
            steps_q   <= steps_q - STEP_WIDTH'(1);
            div_q     <= period_q - DIV_WIDTH'(1);
        end else if (state == RUN && !abort) begin
            div_q <= div_q - DIV_WIDTH'(1);
        end
    end

`ifdef INTERFACE_WHEEL_INDEX_EN
    localparam int REV_W = (COUNTS_PER_REV > 1) ? $clog2(COUNTS_PER_REV) : 1;

    logic [REV_W-1:0] rev, rev_next;
    logic [1:0]       phase_after;

    assign phase_after = step_en ? phase_next : phase;

    always_comb begin
        rev_next = rev;
        if (step_en) begin
            if (dir_q) rev_next = (rev == REV_W'(COUNTS_PER_REV - 1)) ? '0 : rev + REV_W'(1);
            else       rev_next = (rev == '0) ? REV_W'(COUNTS_PER_REV - 1) : rev - REV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rev <= '0;
            Z   <= 1'b1;
        end else begin
            rev <= rev_next;
            Z   <= (rev_next == '0) && (phase_after == 2'd0);
        end
    end
`else
    assign Z = 1'b0;
`endif
endmodule
